// File: rtl/pkg_cpu_defs.sv
// Shared 6502 control encodings: PC sequencer commands, vector selects, sequencer states.
// Also provides the vector byte address helper used by the PC sequencer.
package pkg_cpu_defs;

    localparam logic [2:0] CMD_NOP    = 3'd0;
    localparam logic [2:0] CMD_INC    = 3'd1;
    localparam logic [2:0] CMD_JMP    = 3'd2;
    localparam logic [2:0] CMD_BRANCH = 3'd3;
    localparam logic [2:0] CMD_VECTOR = 3'd4;

    localparam logic [1:0] VEC_NMI   = 2'd0;
    localparam logic [1:0] VEC_RESET = 2'd1;
    localparam logic [1:0] VEC_IRQ   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BR_FIX = 2'd1,
        ST_VEC_LO = 2'd2,
        ST_VEC_HI = 2'd3
    } seq_state_e;

    // Select 3 aliases IRQ; each vector occupies two bytes above the base.
    function automatic logic [15:0] vec_byte_addr(input logic [15:0] base, input logic [1:0] sel);
        logic [1:0] s;
        s = (sel == 2'd3) ? VEC_IRQ : sel;
        return base + {13'd0, s, 1'b0};
    endfunction

endpackage

// File: rtl/pc_branch_add.sv
// Signed 8-bit relative add on PCL: new PCL, raw carry and page-cross flag.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module pc_branch_add (
    input  logic [7:0] pcl,
    input  logic [7:0] offset,
    output logic [7:0] new_pcl,
    output logic       carry,
    output logic       page_cross
);

    assign {carry, new_pcl} = {1'b0, pcl} + {1'b0, offset};
    // Forward offsets cross on carry-out; backward offsets cross when no carry.
    assign page_cross = offset[7] ? ~carry : carry;

endmodule

// File: rtl/pc_sequencer.sv
// 6502 program counter sequencer: INC, JMP, relative BRANCH with page fix-up, vector fetch.
// Latency: DONE 1 cycle after accept (INC/JMP/short branch), 2 for page-crossing branch, 3 for vector.
// Backpressure: commands are taken only while BUSY is low; CMD_VALID during BUSY is dropped.
module pc_sequencer
    import pkg_cpu_defs::*;
#(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [15:0] VEC_BASE    = 16'hFFFA,
    parameter bit          AUTO_VECTOR = 1'b1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [2:0]  CMD,
    input  logic        CMD_VALID,
    input  logic [7:0]  ADL_DATA,
    input  logic [7:0]  ADH_DATA,
    input  logic [7:0]  OFFSET,
    input  logic [1:0]  VEC_SEL,
    input  logic [7:0]  DATA_IN,
    output logic [15:0] PC_OUT,
    output logic [15:0] VEC_ADDR,
    output logic        VEC_RD,
    output logic        BUSY,
    output logic        DONE,
    output logic        PAGE_CROSS
);

    seq_state_e state;
    logic [7:0] pcl;
    logic [7:0] pch;
    logic       auto_pend;
    logic       br_fwd;

    logic [7:0] br_pcl;
    logic       br_carry;
    logic       br_cross;
    logic [2:0] eff_cmd;
    logic [1:0] eff_sel;

    pc_branch_add u_branch_add (
        .pcl        (pcl),
        .offset     (OFFSET),
        .new_pcl    (br_pcl),
        .carry      (br_carry),
        .page_cross (br_cross)
    );

    // The first edge out of reset is hijacked for the RESET vector fetch.
    always_comb begin
        eff_cmd = CMD_NOP;
        eff_sel = VEC_SEL;
        if (auto_pend) begin
            eff_cmd = CMD_VECTOR;
            eff_sel = VEC_RESET;
        end else if (CMD_VALID) begin
            eff_cmd = CMD;
        end
    end

    assign PC_OUT = {pch, pcl};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            {pch, pcl} <= RESET_PC;
            state      <= ST_IDLE;
            auto_pend  <= AUTO_VECTOR;
            br_fwd     <= 1'b0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            PAGE_CROSS <= 1'b0;
            VEC_RD     <= 1'b0;
            VEC_ADDR   <= 16'h0000;
        end else begin
            DONE       <= 1'b0;
            PAGE_CROSS <= 1'b0;
            auto_pend  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    case (eff_cmd)
                        CMD_INC: begin
                            {pch, pcl} <= {pch, pcl} + 16'd1;
                            DONE       <= 1'b1;
                        end
                        CMD_JMP: begin
                            pch  <= ADH_DATA;
                            pcl  <= ADL_DATA;
                            DONE <= 1'b1;
                        end
                        CMD_BRANCH: begin
                            pcl    <= br_pcl;
                            br_fwd <= br_carry;
                            if (br_cross) begin
                                state <= ST_BR_FIX;
                                BUSY  <= 1'b1;
                            end else begin
                                DONE <= 1'b1;
                            end
                        end
                        CMD_VECTOR: begin
                            state    <= ST_VEC_LO;
                            BUSY     <= 1'b1;
                            VEC_RD   <= 1'b1;
                            VEC_ADDR <= vec_byte_addr(VEC_BASE, eff_sel);
                        end
                        default: ;
                    endcase
                end
                ST_BR_FIX: begin
                    pch        <= br_fwd ? pch + 8'd1 : pch - 8'd1;
                    state      <= ST_IDLE;
                    BUSY       <= 1'b0;
                    DONE       <= 1'b1;
                    PAGE_CROSS <= 1'b1;
                end
                ST_VEC_LO: begin
                    pcl      <= DATA_IN;
                    state    <= ST_VEC_HI;
                    VEC_ADDR <= VEC_ADDR + 16'd1;
                end
                ST_VEC_HI: begin
                    pch      <= DATA_IN;
                    state    <= ST_IDLE;
                    VEC_RD   <= 1'b0;
                    VEC_ADDR <= 16'h0000;
                    BUSY     <= 1'b0;
                    DONE     <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized scoreboard bench for pc_sequencer with an arithmetic reference model.
module tb_pc_sequencer;

    localparam int VB = 'hFFFA;
    localparam logic [2:0] C_NOP = 3'd0, C_INC = 3'd1, C_JMP = 3'd2, C_BR = 3'd3, C_VEC = 3'd4;

    logic        CLK, RST_N;
    logic [2:0]  CMD;
    logic        CMD_VALID;
    logic [7:0]  ADL_DATA, ADH_DATA, OFFSET, DATA_IN;
    logic [1:0]  VEC_SEL;
    logic [15:0] PC_OUT, VEC_ADDR;
    logic        VEC_RD, BUSY, DONE, PAGE_CROSS;

    pc_sequencer #(.RESET_PC(16'h0000), .VEC_BASE(16'hFFFA), .AUTO_VECTOR(1'b1)) dut (
        .CLK(CLK), .RST_N(RST_N), .CMD(CMD), .CMD_VALID(CMD_VALID),
        .ADL_DATA(ADL_DATA), .ADH_DATA(ADH_DATA), .OFFSET(OFFSET), .VEC_SEL(VEC_SEL),
        .DATA_IN(DATA_IN), .PC_OUT(PC_OUT), .VEC_ADDR(VEC_ADDR), .VEC_RD(VEC_RD),
        .BUSY(BUSY), .DONE(DONE), .PAGE_CROSS(PAGE_CROSS)
    );

    typedef struct { logic [15:0] pc; logic pcx; int cyc; } exp_t;
    typedef struct { logic [15:0] a; int cyc; } rd_t;

    exp_t exp_q[$];
    rd_t  rd_q[$];
    logic [7:0] vmem [0:5];
    int   cyc = 0, free_edge = 0, busy_lo = 0, busy_hi = -1;
    int   m_pc = 0;
    int   n_checks = 0, n_fail = 0;
    int   didx;
    logic exp_rd, exp_done, exp_busy;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    always_comb begin
        didx = int'(VEC_ADDR) - VB;
        DATA_IN = 8'hEE;
        if (VEC_RD && didx >= 0 && didx < 6) DATA_IN = vmem[didx];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: whole-PC arithmetic, accept edge A known to the caller.
    task automatic push_cmd(input logic [2:0] c, input int adl, input int adh, input int off,
                            input int sel, input int a_edge);
        int np, l, so, s, va;
        logic x;
        x = 1'b0;
        case (c)
            C_INC: begin np = (m_pc + 1) & 'hFFFF; l = 1; end
            C_JMP: begin np = adh * 256 + adl; l = 1; end
            C_BR: begin
                so = (off >= 128) ? off - 256 : off;
                np = (m_pc + so) & 'hFFFF;
                x  = ((np >> 8) != (m_pc >> 8));
                l  = x ? 2 : 1;
            end
            C_VEC: begin
                s  = (sel == 3) ? 2 : sel;
                va = VB + 2 * s;
                np = int'(vmem[va - VB + 1]) * 256 + int'(vmem[va - VB]);
                l  = 3;
                rd_q.push_back('{16'(va), a_edge});
                rd_q.push_back('{16'(va + 1), a_edge + 1});
            end
            default: return;
        endcase
        m_pc      = np;
        busy_lo   = a_edge;
        busy_hi   = a_edge + l - 2;
        free_edge = a_edge + l;
        exp_q.push_back('{16'(np), x, a_edge + l - 1});
    endtask

    always @(negedge CLK) begin
        if (RST_N) begin
            exp_rd = (rd_q.size() > 0) && (rd_q[0].cyc == cyc);
            check("vec_rd", 32'(VEC_RD), 32'(exp_rd));
            if (exp_rd) begin
                check("vec_addr", 32'(VEC_ADDR), 32'(rd_q[0].a));
                void'(rd_q.pop_front());
            end else begin
                check("vec_addr_idle", 32'(VEC_ADDR), 32'h0);
            end
            exp_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
            check("busy", 32'(BUSY), 32'(exp_busy));
            exp_done = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
            check("done", 32'(DONE), 32'(exp_done));
            if (exp_done) begin
                check("done_pc", 32'(PC_OUT), 32'(exp_q[0].pc));
                check("page_cross", 32'(PAGE_CROSS), 32'(exp_q[0].pcx));
                void'(exp_q.pop_front());
            end else begin
                check("page_cross_idle", 32'(PAGE_CROSS), 32'h0);
                if (exp_q.size() == 0) check("pc_hold", 32'(PC_OUT), 32'(m_pc));
            end
        end
    end

    task automatic wait_free();
        int guard;
        guard = 0;
        while (cyc + 1 < free_edge) begin
            CMD_VALID = 1'b1;
            CMD = C_INC;
            @(negedge CLK);
            guard++;
            if (guard > 50) begin
                check("wait_free_timeout", 32'(guard), 32'h0);
                break;
            end
        end
        CMD_VALID = 1'b0;
        CMD = C_NOP;
    endtask

    task automatic issue(input logic [2:0] c, input logic [7:0] adl, input logic [7:0] adh,
                         input logic [7:0] off, input logic [1:0] sel);
        wait_free();
        CMD = c; ADL_DATA = adl; ADH_DATA = adh; OFFSET = off; VEC_SEL = sel;
        CMD_VALID = 1'b1;
        push_cmd(c, int'(adl), int'(adh), int'(off), int'(sel), cyc + 1);
        @(negedge CLK);
        CMD_VALID = 1'b0;
        CMD = C_NOP;
    endtask

    task automatic release_reset();
        @(negedge CLK);
        RST_N = 1'b1;
        CMD_VALID = 1'b1;
        CMD = C_INC;
        push_cmd(C_VEC, 0, 0, 0, 1, cyc + 1);
        @(negedge CLK);
        CMD_VALID = 1'b0;
        CMD = C_NOP;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [2:0] rc;
        RST_N = 1'b0; CMD = C_NOP; CMD_VALID = 1'b0;
        ADL_DATA = 8'h0; ADH_DATA = 8'h0; OFFSET = 8'h0; VEC_SEL = 2'd0;
        for (int i = 0; i < 6; i++) vmem[i] = 8'($urandom);
        vmem[2] = 8'h34;
        vmem[3] = 8'h12;

        repeat (2) @(negedge CLK);
        #1;
        check("rst_pc", 32'(PC_OUT), 32'h0);
        check("rst_busy", 32'(BUSY), 32'h0);
        check("rst_done", 32'(DONE), 32'h0);
        check("rst_vec_rd", 32'(VEC_RD), 32'h0);
        check("rst_vec_addr", 32'(VEC_ADDR), 32'h0);
        check("rst_page_cross", 32'(PAGE_CROSS), 32'h0);

        release_reset();
        wait_free();
        check("auto_vector_pc", 32'(PC_OUT), 32'h1234);

        issue(C_JMP, 8'hFF, 8'h12, 8'h0, 2'd0);
        issue(C_INC, 8'h0, 8'h0, 8'h0, 2'd0);
        wait_free();
        check("inc_carry", 32'(PC_OUT), 32'h1300);
        issue(C_JMP, 8'hFF, 8'hFF, 8'h0, 2'd0);
        issue(C_INC, 8'h0, 8'h0, 8'h0, 2'd0);
        wait_free();
        check("inc_wrap", 32'(PC_OUT), 32'h0000);
        issue(C_JMP, 8'h55, 8'hAA, 8'h0, 2'd0);
        wait_free();
        check("jmp", 32'(PC_OUT), 32'hAA55);

        issue(C_JMP, 8'h80, 8'h10, 8'h0, 2'd0);
        issue(C_BR, 8'h0, 8'h0, 8'h10, 2'd0);
        wait_free();
        check("br_short", 32'(PC_OUT), 32'h1090);
        issue(C_JMP, 8'hF0, 8'h10, 8'h0, 2'd0);
        issue(C_BR, 8'h0, 8'h0, 8'h20, 2'd0);
        check("br_fwd_mid", 32'(PC_OUT), 32'h1010);
        wait_free();
        check("br_fwd_cross", 32'(PC_OUT), 32'h1110);
        issue(C_JMP, 8'h05, 8'h10, 8'h0, 2'd0);
        issue(C_BR, 8'h0, 8'h0, 8'hF0, 2'd0);
        wait_free();
        check("br_back_cross", 32'(PC_OUT), 32'h0FF5);

        issue(C_VEC, 8'h0, 8'h0, 8'h0, 2'd0);
        wait_free();
        check("nmi_vector", 32'(PC_OUT), {16'h0, vmem[1], vmem[0]});

        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 9))
                0, 1: issue(C_JMP, ($urandom_range(0, 1) != 0) ? 8'($urandom_range(240, 255)) : 8'($urandom),
                            8'($urandom), 8'h0, 2'd0);
                2, 3: issue(C_INC, 8'h0, 8'h0, 8'h0, 2'd0);
                4, 5, 6: issue(C_BR, 8'h0, 8'h0, 8'($urandom), 2'd0);
                7: issue(C_VEC, 8'h0, 8'h0, 8'h0, 2'($urandom));
                8: begin
                    wait_free();
                    rc = 3'($urandom_range(4, 7));
                    CMD = (rc == 3'd4) ? C_NOP : rc;
                    CMD_VALID = 1'b1;
                    @(negedge CLK);
                    CMD_VALID = 1'b0;
                end
                default: repeat ($urandom_range(1, 3)) @(negedge CLK);
            endcase
        end

        issue(C_VEC, 8'h0, 8'h0, 8'h0, 2'd2);
        @(negedge CLK);
        #2;
        RST_N = 1'b0;
        exp_q.delete();
        rd_q.delete();
        m_pc = 0;
        busy_hi = -1;
        free_edge = 0;
        #1;
        check("midop_rst_pc", 32'(PC_OUT), 32'h0);
        check("midop_rst_busy", 32'(BUSY), 32'h0);
        check("midop_rst_vec_rd", 32'(VEC_RD), 32'h0);
        repeat (2) @(negedge CLK);
        release_reset();
        wait_free();
        check("reauto_vector_pc", 32'(PC_OUT), 32'h1234);

        repeat (4) @(negedge CLK);
        check("exp_q_drained", 32'(exp_q.size()), 32'h0);
        check("rd_q_drained", 32'(rd_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Sequences the 16-bit program counter, i.e. the PCL and PCH/ADH-select register pair, for the 6502 core.
- Performs the following PC operations on command from the control unit:
  - increment with carry from PCL into PCH;
  - absolute load from the ADL/ADH buses;
  - relative branch with page-cross fix-up;
  - two-byte vector fetch (NMI/RESET/IRQ).
- Sits between the instruction decoder/timing logic and the PC registers. Drives the PC onto the address bus.

Parameters:
- RESET_PC, 16'h0000, PC value held while RST_N is low.
- VEC_BASE, 16'hFFFA, address of the NMI vector low byte. RESET = VEC_BASE+2, IRQ = VEC_BASE+4.
- AUTO_VECTOR, 1, when 1 a RESET vector fetch starts automatically on the first clock after reset release.

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- CMD  in  3  command: 0 NOP, 1 INC, 2 JMP, 3 BRANCH, 4 VECTOR, 5-7 treated as NOP.
- CMD_VALID  in  1  CMD is sampled when high and BUSY is low.
- ADL_DATA  in  8  jump target low byte (JMP).
- ADH_DATA  in  8  jump target high byte (JMP).
- OFFSET  in  8  signed two's-complement branch offset (BRANCH).
- VEC_SEL  in  2  0 NMI, 1 RESET, 2 IRQ, 3 treated as IRQ.
- DATA_IN  in  8  memory read data. Valid in the same cycle VEC_RD is high (combinational read).
- PC_OUT  out  16  current PC {PCH, PCL}.
- VEC_ADDR  out  16  vector byte address. Valid while VEC_RD is high, else 16'h0000.
- VEC_RD  out  1  vector read strobe.
- BUSY  out  1  high while a multi-cycle operation is in progress.
- DONE  out  1  one-cycle pulse on completion of any non-NOP command.
- PAGE_CROSS  out  1  one-cycle pulse, coincident with DONE, when a BRANCH crossed a page.

Behaviour:
- Reset (RST_N low, asynchronous):
  - PC = RESET_PC; state IDLE.
  - BUSY, DONE, PAGE_CROSS, VEC_RD = 0; VEC_ADDR = 0.
- Reset asserted mid-operation aborts it immediately. No partial PC update survives.
- States: IDLE, BR_FIX, VEC_LO, VEC_HI.
- IDLE with CMD_VALID high:
  - INC: PC <= PC+1, modulo 2^16 (FFFF -> 0000). DONE=1 next cycle.
  - JMP: PC <= {ADH_DATA, ADL_DATA}. DONE=1 next cycle.
  - BRANCH, first edge: {c, PCL} <= PCL + OFFSET[7:0], 9-bit add.
    - Page crossed when (OFFSET[7]==0 and c==1) or (OFFSET[7]==1 and c==0).
    - No cross: DONE=1 next cycle, PAGE_CROSS=0.
    - Cross: go to BR_FIX, BUSY=1.
  - VECTOR: go to VEC_LO with BUSY=1, VEC_RD=1, VEC_ADDR = VEC_BASE + 2*sel (sel 3 -> 2).
- BR_FIX: PCH <= PCH+1 (forward) or PCH-1 (backward), wrapping mod 256. Return to IDLE; DONE=1 and PAGE_CROSS=1 next cycle.
- VEC_LO: PCL <= DATA_IN. Go to VEC_HI; VEC_ADDR increments by 1, VEC_RD stays 1.
- VEC_HI: PCH <= DATA_IN. Go to IDLE; VEC_RD=0, BUSY=0, DONE=1 next cycle.
- Latency from command accept to DONE:
  - INC, JMP, non-crossing BRANCH: 1 cycle.
  - Crossing BRANCH: 2 cycles.
  - VECTOR: 3 cycles.
- BUSY is low in the cycle DONE pulses, so a new command may be accepted in the DONE cycle (back-to-back).
- CMD_VALID while BUSY is ignored. It is not queued.
- NOP and codes 5-7 do not change the PC and produce no DONE.
- AUTO_VECTOR=1: first rising edge with RST_N high forces a VECTOR with sel=1, regardless of CMD/CMD_VALID.
- PC_OUT is a registered output, reflecting the PC after the last edge.

Decomposition:
- Shared package pkg_cpu_defs holds:
  - CMD_* encodings;
  - VEC_NMI/VEC_RESET/VEC_IRQ select codes;
  - sequencer state encodings.
- One natural sub-module: pc_branch_add, a combinational 8-bit signed add producing the new PCL, carry and page-cross flag. It is reusable by the effective-address logic.

Test Plan:
- AUTO_VECTOR=1, release reset, DATA_IN=34 at FFFC and 12 at FFFD:
  - VEC_RD high for 2 cycles, addresses FFFC then FFFD;
  - PC_OUT=1234, DONE 3 cycles after release.
- PC=12FF, INC -> PC_OUT=1300, DONE 1 cycle. PC=FFFF, INC -> 0000.
- JMP with ADH=AA, ADL=55 -> PC_OUT=AA55, DONE 1 cycle after accept.
- Branches:
  - PC=1080, OFFSET=10 -> 1090, PAGE_CROSS=0, 1 cycle.
  - PC=10F0, OFFSET=20 -> 1110, PAGE_CROSS=1, 2 cycles, intermediate PC_OUT=1010.
  - PC=1005, OFFSET=F0 (-16) -> 0FF5, PAGE_CROSS=1.
- Robustness:
  - VECTOR sel=0; CMD_VALID+INC during BUSY is ignored; final PC equals the NMI vector.
  - RST_N pulsed low during VEC_HI -> PC_OUT=RESET_PC immediately, BUSY=0.
